fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Sequences a radix-2 decimation-in-time in-place FFT of 2^LOG2N points, stage by stage and butterfly by butterfly.
- Drives the shared 16-entry twiddle ROM, which has one registered output, a real/imag select and a 4-bit index. Fetches the real part first, then the imaginary part.
- Issues one butterfly command at a time to the butterfly datapath (addresses plus twiddle) using a valid/ready handshake.
- Drains the datapath between stages and pulses done at the end. Input data must already be in bit-reversed order in sample RAM.

Parameters:
- LOG2N, 4, log2 of FFT length. Legal values 1..4.
- TW_W, 16, twiddle word width, Q1.15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse when the transform is complete
- tw_real_imag  out  1  twiddle ROM select: 0 = real, 1 = imag
- tw_num  out  4  twiddle ROM index
- tw_val  in  TW_W  twiddle ROM output, registered, 1-cycle latency
- bfly_valid  out  1  butterfly command valid
- bfly_ready  in  1  datapath accepts the command
- bfly_addr_a  out  LOG2N  top operand address
- bfly_addr_b  out  LOG2N  bottom operand address
- bfly_tw_re  out  TW_W  twiddle real part
- bfly_tw_im  out  TW_W  twiddle imaginary part
- stage  out  2  current stage index
- bfly_idle  in  1  datapath has no outstanding writes

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, bfly_valid, tw_real_imag, tw_num, addresses, twiddles, stage. Internal counters s = 0, b = 0. Reset in any state aborts immediately; no done is produced.
- Indexing, with span = 1<<s and pos = b & (span-1):
  - addr_a = ((b>>s) << (s+1)) + pos
  - addr_b = addr_a + span
  - tw_num = pos << (3-s)
  - All arithmetic is unsigned, truncated to the port width.
- Stage s runs 0..LOG2N-1. Butterfly b runs 0..2^(LOG2N-1)-1.
- IDLE:
  - start=1 → TRE, busy goes to 1, s = b = 0.
  - start=0 → remain in IDLE.
- TRE (1 cycle): tw_real_imag=0, tw_num=k → TIM.
- TIM (1 cycle): tw_real_imag=1, tw_num=k. tw_val holds the real part; register it into bfly_tw_re at the cycle end → TCAP.
- TCAP (1 cycle): tw_val holds the imaginary part; register it into bfly_tw_im. Register addr_a and addr_b → ISSUE.
- ISSUE:
  - bfly_valid=1. All bfly_* outputs are held stable until bfly_valid && bfly_ready at a clock edge.
  - On transfer, if b is not last: b+1 → TRE. If b is last: b=0 → DRAIN.
  - bfly_valid drops in the cycle after the transfer.
- DRAIN (at least 1 cycle): wait for bfly_idle=1.
  - If s is not last: s+1 → TRE.
  - If s is last → DONE.
- DONE (1 cycle): done=1, busy=1 → IDLE (busy=0 next cycle).
- start while busy is ignored and has no side effect. start held high in the DONE cycle is not accepted until IDLE.
- Output stability:
  - tw_num and tw_real_imag hold their last values outside TRE/TIM.
  - The stage output equals s throughout.
- Minimum cycles per butterfly is 4.
- With ready=1 and idle=1, the start-sampling edge to the done-high cycle is (2^(LOG2N-1)·4 + 1)·LOG2N cycles.
  - LOG2N=4: 132.
  - LOG2N=2: 18.

Test Plan:
- Reset and LOG2N=4 golden run:
  - Stimulus: rst, then start for 1 cycle; ready=1, idle=1.
  - Required response: all outputs 0 during reset; 32 transfers in order; done exactly 132 cycles after start; busy low the next cycle.
- Address and twiddle checks (LUT model connected):
  - s0 b0 → a=0, b=1, tw_num=0, re=0x8000, im=0x0000.
  - s1 b1 → a=1, b=3, tw_num=4, re=0x0000, im=0x8000.
  - s3 b5 → a=5, b=13, tw_num=5, re=0xCF05, im=0x89BF.
- Backpressure: hold bfly_ready=0 for 5 cycles at s2 b3 → bfly_valid, addresses and twiddles unchanged for all 5 cycles; exactly one transfer is counted.
- Drain: hold bfly_idle=0 for 3 cycles after the last stage-0 transfer → DRAIN lasts 4 cycles; first stage-1 TRE is delayed by 3; total is 135 cycles.
- Start while busy: pulse start at cycles 10 and 132 → no restart; a single done at 132.
- Reset mid-operation, and LOG2N=2 build:
  - Assert rst during s1 ISSUE → all outputs 0 the next cycle; no done; a new start then runs a full 132-cycle transform.
  - LOG2N=2 build: done at 18 cycles; s1 b1 → a=1, b=3, tw_num=4.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT of 2^LOG2N points.
// For each butterfly it fetches the twiddle (real, then imaginary) from the shared
// registered ROM, then issues one command to the datapath over valid/ready.
// Between stages it waits for the datapath to drain, and it pulses done at the end.
module fft_stage_sequencer #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned TW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             tw_real_imag,
  output logic [3:0]       tw_num,
  input  logic [TW_W-1:0]  tw_val,
  output logic             bfly_valid,
  input  logic             bfly_ready,
  output logic [LOG2N-1:0] bfly_addr_a,
  output logic [LOG2N-1:0] bfly_addr_b,
  output logic [TW_W-1:0]  bfly_tw_re,
  output logic [TW_W-1:0]  bfly_tw_im,
  output logic [1:0]       stage,
  input  logic             bfly_idle
);

  localparam logic [3:0] BLast = 4'((1 << (LOG2N - 1)) - 1);
  localparam logic [1:0] SLast = 2'(LOG2N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTre,
    StTim,
    StTcap,
    StIssue,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        s_q, s_d;
  logic [3:0]        b_q, b_d;
  logic              ri_q, ri_d;
  logic [3:0]        tw_num_q, tw_num_d;
  logic [LOG2N-1:0]  addr_a_q, addr_a_d;
  logic [LOG2N-1:0]  addr_b_q, addr_b_d;
  logic [TW_W-1:0]   tw_re_q, tw_re_d;
  logic [TW_W-1:0]   tw_im_q, tw_im_d;

  // Position of butterfly b inside its group at stage s.
  function automatic logic [31:0] pos_of(input logic [1:0] s, input logic [3:0] b);
    return 32'(b) & ((32'd1 << s) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_a_of(input logic [1:0] s, input logic [3:0] b);
    return ((32'(b) >> s) << (32'(s) + 32'd1)) + pos_of(s, b);
  endfunction

  // Twiddle index into the 16-entry ROM; ROM is always indexed for N=16.
  function automatic logic [3:0] tw_of(input logic [1:0] s, input logic [3:0] b);
    return 4'(pos_of(s, b) << (32'd3 - 32'(s)));
  endfunction

  // Next-state and datapath register loads.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    ri_d     = ri_q;
    tw_num_d = tw_num_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_re_d  = tw_re_q;
    tw_im_d  = tw_im_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StTre;
          s_d      = 2'd0;
          b_d      = 4'd0;
          ri_d     = 1'b0;
          tw_num_d = 4'd0;
        end
      end
      StTre: begin
        state_d = StTim;
        ri_d    = 1'b1;
      end
      StTim: begin
        // ROM output now carries the real part requested in TRE.
        tw_re_d = tw_val;
        state_d = StTcap;
      end
      StTcap: begin
        tw_im_d  = tw_val;
        addr_a_d = LOG2N'(addr_a_of(s_q, b_q));
        addr_b_d = LOG2N'(addr_a_of(s_q, b_q) + (32'd1 << s_q));
        state_d  = StIssue;
      end
      StIssue: begin
        if (bfly_ready) begin
          if (b_q == BLast) begin
            b_d     = 4'd0;
            state_d = StDrain;
          end else begin
            b_d      = b_q + 4'd1;
            ri_d     = 1'b0;
            tw_num_d = tw_of(s_q, b_q + 4'd1);
            state_d  = StTre;
          end
        end
      end
      StDrain: begin
        if (bfly_idle) begin
          if (s_q == SLast) begin
            state_d = StDone;
          end else begin
            s_d      = s_q + 2'd1;
            ri_d     = 1'b0;
            tw_num_d = tw_of(s_q + 2'd1, 4'd0);
            state_d  = StTre;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      s_q      <= 2'd0;
      b_q      <= 4'd0;
      ri_q     <= 1'b0;
      tw_num_q <= 4'd0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_re_q  <= '0;
      tw_im_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      ri_q     <= ri_d;
      tw_num_q <= tw_num_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_re_q  <= tw_re_d;
      tw_im_q  <= tw_im_d;
    end
  end

  // Output decode.
  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    bfly_valid   = (state_q == StIssue);
    tw_real_imag = ri_q;
    tw_num       = tw_num_q;
    bfly_addr_a  = addr_a_q;
    bfly_addr_b  = addr_b_q;
    bfly_tw_re   = tw_re_q;
    bfly_tw_im   = tw_im_q;
    stage        = s_q;
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: LOG2N=4 main instance plus a LOG2N=2 instance,
// each fed by a registered twiddle ROM model.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, bfly_ready, bfly_idle;
  logic        busy, done, tw_real_imag, bfly_valid;
  logic [3:0]  tw_num, addr_a, addr_b;
  logic [15:0] tw_val, tw_re, tw_im;
  logic [1:0]  stage;

  logic        start2, ready2, idle2;
  logic        busy2, done2, ri2, valid2;
  logic [3:0]  tw_num2;
  logic [1:0]  a2, b2, stage2;
  logic [15:0] tw_val2, re2, im2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  tw;
    logic [15:0] re;
    logic [15:0] im;
  } xfer_t;

  xfer_t xq[$];
  xfer_t xq2[$];

  logic [15:0] re_tab [16];
  logic [15:0] im_tab [16];

  fft_stage_sequencer #(.LOG2N(4), .TW_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .tw_real_imag (tw_real_imag),
    .tw_num       (tw_num),
    .tw_val       (tw_val),
    .bfly_valid   (bfly_valid),
    .bfly_ready   (bfly_ready),
    .bfly_addr_a  (addr_a),
    .bfly_addr_b  (addr_b),
    .bfly_tw_re   (tw_re),
    .bfly_tw_im   (tw_im),
    .stage        (stage),
    .bfly_idle    (bfly_idle)
  );

  fft_stage_sequencer #(.LOG2N(2), .TW_W(16)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .busy         (busy2),
    .done         (done2),
    .tw_real_imag (ri2),
    .tw_num       (tw_num2),
    .tw_val       (tw_val2),
    .bfly_valid   (valid2),
    .bfly_ready   (ready2),
    .bfly_addr_a  (a2),
    .bfly_addr_b  (b2),
    .bfly_tw_re   (re2),
    .bfly_tw_im   (im2),
    .stage        (stage2),
    .bfly_idle    (idle2)
  );

  initial begin
    for (int k = 0; k < 16; k++) begin
      re_tab[k] = 16'h1000 + 16'(k) * 16'h0111;
      im_tab[k] = 16'h2000 + 16'(k) * 16'h0123;
    end
    re_tab[0] = 16'h8000; im_tab[0] = 16'h0000;
    re_tab[4] = 16'h0000; im_tab[4] = 16'h8000;
    re_tab[5] = 16'hCF05; im_tab[5] = 16'h89BF;
  end

  // Registered twiddle ROMs, one-cycle latency.
  always @(posedge clk) tw_val  <= tw_real_imag ? im_tab[tw_num]  : re_tab[tw_num];
  always @(posedge clk) tw_val2 <= ri2          ? im_tab[tw_num2] : re_tab[tw_num2];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so a handshake seen here transfers next edge.
  always @(negedge clk) begin
    if (bfly_valid && bfly_ready)
      xq.push_back('{st: stage, a: addr_a, b: addr_b, tw: tw_num, re: tw_re, im: tw_im});
    if (valid2 && ready2)
      xq2.push_back('{st: stage2, a: {2'b00, a2}, b: {2'b00, b2}, tw: tw_num2, re: re2, im: im2});
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin
        lat = cyc - t0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bfly_ready = 1'b1; bfly_idle = 1'b1;
    start2 = 1'b0; ready2 = 1'b1; idle2 = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, done, bfly_valid, tw_real_imag} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, bfly_valid, tw_real_imag});
    end
    total++;
    if ({tw_num, addr_a, addr_b, stage} !== 14'd0) begin
      bad++;
      $display("FAIL reset_idx: got tw=%0d a=%0d b=%0d st=%0d want 0", tw_num, addr_a, addr_b,
               stage);
    end
    total++;
    if ({tw_re, tw_im} !== 32'd0) begin
      bad++;
      $display("FAIL reset_tw: got %h %h want 0", tw_re, tw_im);
    end
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: busy got %b want 0", busy);
    end
  endtask

  task automatic test_golden();
    int t0, lat, dc0, idx;
    xfer_t x;
    xq.delete();
    dc0 = done_cnt;
    start_run(t0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    wait_done(t0, lat);
    total++;
    if (lat !== 132) begin
      bad++;
      $display("FAIL golden_latency: got %0d want 132", lat);
    end
    tick();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL after_done: busy,done got %b want 00", {busy, done});
    end
    total++;
    if (done_cnt - dc0 !== 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - dc0);
    end
    total++;
    if (xq.size() !== 32) begin
      bad++;
      $display("FAIL golden_count: got %0d want 32", xq.size());
    end
    // Expected order: per stage, groups of 2*span, offsets within group.
    idx = 0;
    for (int s = 0; s < 4; s++) begin
      for (int g = 0; g < 8 / (1 << s); g++) begin
        for (int p = 0; p < (1 << s); p++) begin
          int ea, etw;
          ea  = g * 2 * (1 << s) + p;
          etw = p * (8 / (1 << s));
          if (idx < xq.size()) begin
            x = xq[idx];
            total++;
            if (x.st !== 2'(s) || x.a !== 4'(ea) || x.b !== 4'(ea + (1 << s)) ||
                x.tw !== 4'(etw) || x.re !== re_tab[etw] || x.im !== im_tab[etw]) begin
              bad++;
              $display("FAIL order[%0d]: got st=%0d a=%0d b=%0d tw=%0d re=%h im=%h want st=%0d a=%0d b=%0d tw=%0d",
                       idx, x.st, x.a, x.b, x.tw, x.re, x.im, s, ea, ea + (1 << s), etw);
            end
          end
          idx++;
        end
      end
    end
    if (xq.size() >= 30) begin
      total++;
      x = xq[0];
      if ({x.a, x.b, x.tw, x.re, x.im} !== {4'd0, 4'd1, 4'd0, 16'h8000, 16'h0000}) begin
        bad++;
        $display("FAIL s0b0: got a=%0d b=%0d tw=%0d re=%h im=%h want 0 1 0 8000 0000",
                 x.a, x.b, x.tw, x.re, x.im);
      end
      total++;
      x = xq[9];
      if ({x.a, x.b, x.tw, x.re, x.im} !== {4'd1, 4'd3, 4'd4, 16'h0000, 16'h8000}) begin
        bad++;
        $display("FAIL s1b1: got a=%0d b=%0d tw=%0d re=%h im=%h want 1 3 4 0000 8000",
                 x.a, x.b, x.tw, x.re, x.im);
      end
      total++;
      x = xq[29];
      if ({x.a, x.b, x.tw, x.re, x.im} !== {4'd5, 4'd13, 4'd5, 16'hCF05, 16'h89BF}) begin
        bad++;
        $display("FAIL s3b5: got a=%0d b=%0d tw=%0d re=%h im=%h want 5 13 5 cf05 89bf",
                 x.a, x.b, x.tw, x.re, x.im);
      end
    end
  endtask

  task automatic test_backpressure();
    int t0, lat, hits;
    bit found;
    logic [3:0]  ca, cb;
    logic [15:0] cre, cim;
    xq.delete();
    found = 1'b0;
    start_run(t0);
    for (int i = 0; i < 200; i++) begin
      if (bfly_valid && stage == 2'd2 && xq.size() == 19) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL bp_reach: got not-found want s2b3 issue");
    end
    bfly_ready = 1'b0;
    ca = addr_a; cb = addr_b; cre = tw_re; cim = tw_im;
    total++;
    if ({ca, cb} !== {4'd3, 4'd7}) begin
      bad++;
      $display("FAIL bp_addr: got a=%0d b=%0d want 3 7", ca, cb);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bfly_valid !== 1'b1 || addr_a !== ca || addr_b !== cb || tw_re !== cre ||
          tw_im !== cim) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b a=%0d b=%0d re=%h im=%h want 1 %0d %0d %h %h",
                 k, bfly_valid, addr_a, addr_b, tw_re, tw_im, ca, cb, cre, cim);
      end
    end
    bfly_ready = 1'b1;
    wait_done(t0, lat);
    total++;
    if (lat !== 137) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 137", lat);
    end
    hits = 0;
    foreach (xq[i]) if (xq[i].st == 2'd2 && xq[i].a == 4'd3) hits++;
    total++;
    if (hits !== 1 || xq.size() !== 32) begin
      bad++;
      $display("FAIL bp_transfers: got hits=%0d n=%0d want 1 32", hits, xq.size());
    end
    tick();
  endtask

  task automatic test_drain();
    int t0, lat;
    bit found;
    xq.delete();
    found = 1'b0;
    start_run(t0);
    for (int i = 0; i < 200; i++) begin
      if (bfly_valid && stage == 2'd0 && xq.size() == 7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL drain_reach: got not-found want last stage-0 issue");
    end
    bfly_idle = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (stage !== 2'd0 || bfly_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL drain_wait[%0d]: got st=%0d v=%b busy=%b want 0 0 1", k, stage,
                 bfly_valid, busy);
      end
      tick();
    end
    bfly_idle = 1'b1;
    tick();
    total++;
    if (stage !== 2'd1 || cyc - t0 !== 36) begin
      bad++;
      $display("FAIL drain_resume: got st=%0d at %0d want 1 at 36", stage, cyc - t0);
    end
    wait_done(t0, lat);
    total++;
    if (lat !== 135) begin
      bad++;
      $display("FAIL drain_latency: got %0d want 135", lat);
    end
    tick();
  endtask

  task automatic test_start_busy();
    int t0, lat, dc0, n;
    xq.delete();
    dc0 = done_cnt;
    lat = -1;
    start_run(t0);
    for (int i = 0; i < 200; i++) begin
      n = cyc - t0;
      if (n >= 140) break;
      if (done && lat < 0) lat = n;
      start = (n == 10 || n == 132);
      tick();
    end
    start = 1'b0;
    total++;
    if (lat !== 132 || done_cnt - dc0 !== 1) begin
      bad++;
      $display("FAIL sb_done: got lat=%0d pulses=%0d want 132 1", lat, done_cnt - dc0);
    end
    total++;
    if (busy !== 1'b0 || xq.size() !== 32) begin
      bad++;
      $display("FAIL sb_restart: got busy=%b n=%0d want 0 32", busy, xq.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, lat, dc0;
    bit found;
    found = 1'b0;
    start_run(t0);
    for (int i = 0; i < 200; i++) begin
      if (bfly_valid && stage == 2'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reach: got not-found want s1 issue");
    end
    dc0 = done_cnt;
    rst = 1'b1;
    tick();
    total++;
    if ({busy, done, bfly_valid, tw_real_imag, tw_num, addr_a, addr_b, stage} !== 18'd0 ||
        {tw_re, tw_im} !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b v=%b st=%0d a=%0d b=%0d tw=%0d re=%h im=%h want 0",
               busy, bfly_valid, stage, addr_a, addr_b, tw_num, tw_re, tw_im);
    end
    rst = 1'b0;
    repeat (5) tick();
    total++;
    if (done_cnt !== dc0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_nodone: got pulses=%0d busy=%b want 0 0", done_cnt - dc0, busy);
    end
    xq.delete();
    start_run(t0);
    wait_done(t0, lat);
    total++;
    if (lat !== 132 || xq.size() !== 32) begin
      bad++;
      $display("FAIL mid_rerun: got lat=%0d n=%0d want 132 32", lat, xq.size());
    end
    tick();
  endtask

  task automatic test_log2n2();
    int t0, lat;
    xq2.delete();
    lat = -1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done2) begin
        lat = cyc - t0;
        break;
      end
    end
    total++;
    if (lat !== 18) begin
      bad++;
      $display("FAIL n4_latency: got %0d want 18", lat);
    end
    total++;
    if (xq2.size() !== 4) begin
      bad++;
      $display("FAIL n4_count: got %0d want 4", xq2.size());
    end else begin
      total++;
      if ({xq2[1].a, xq2[1].b, xq2[2].a, xq2[2].b} !== {4'd2, 4'd3, 4'd0, 4'd2}) begin
        bad++;
        $display("FAIL n4_mid: got %0d %0d %0d %0d want 2 3 0 2", xq2[1].a, xq2[1].b,
                 xq2[2].a, xq2[2].b);
      end
      total++;
      if ({xq2[3].st, xq2[3].a, xq2[3].b, xq2[3].tw, xq2[3].re, xq2[3].im} !==
          {2'd1, 4'd1, 4'd3, 4'd4, 16'h0000, 16'h8000}) begin
        bad++;
        $display("FAIL n4_s1b1: got st=%0d a=%0d b=%0d tw=%0d re=%h im=%h want 1 1 3 4 0000 8000",
                 xq2[3].st, xq2[3].a, xq2[3].b, xq2[3].tw, xq2[3].re, xq2[3].im);
      end
    end
    tick();
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL n4_idle: busy got %b want 0", busy2);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_backpressure();
    test_drain();
    test_start_busy();
    test_reset_mid();
    test_log2n2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
